// File: rtl/sram_stream_reader_pkg.sv
// rtl/sram_stream_reader_pkg.sv - shared state encodings and buffer depth for the SRAM stream reader
package sram_stream_reader_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   // Two slots: one word being presented plus one returning from the SRAM
   localparam int BUF_DEPTH = 2;
   localparam int BUF_PTR_W = $clog2(BUF_DEPTH);

endpackage

// File: rtl/sram_stream_buf.sv
// rtl/sram_stream_buf.sv - 2-entry synchronous FIFO holding returned SRAM words, with flush
module sram_stream_buf
   import sram_stream_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0]     mem [BUF_DEPTH];
   logic [BUF_PTR_W-1:0] wr_ptr;
   logic [BUF_PTR_W-1:0] rd_ptr;
   logic [1:0]           count;

   // Storage and pointers; flush drops everything including a same-cycle push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + BUF_PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + BUF_PTR_W'(1);
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != 2'd0);
   assign occupancy  = count;

endmodule

// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - streams len words from a sync-read SRAM onto a valid/ready stream (option: SRAM_STREAM_READER_LOOP_EN)
module sram_stream_reader
   import sram_stream_reader_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
`ifdef SRAM_STREAM_READER_LOOP_EN
   input  logic                  loop,
`endif
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic                  sram_ren,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [WIDTH-1:0]      sram_rdata,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  inflight;
   logic [1:0]            occ;
   logic                  pop;
   logic [2:0]            level;

`ifdef SRAM_STREAM_READER_LOOP_EN
   logic                  loop_q;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   len_q;
`endif

   assign pop = out_valid && out_ready;

   // Slots committed after this edge; a read may issue only if its data is guaranteed a slot
   assign level     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign sram_ren  = (state == S_RUN) && (level < 3'd2);
   assign sram_addr = cur_addr;
   assign busy      = (state != S_IDLE);

   sram_stream_buf #(
      .WIDTH(WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (sram_rdata),
      .pop       (pop),
      .flush     (abort),
      .head_data (out_data),
      .head_valid(out_valid),
      .occupancy (occ)
   );

   // Transfer FSM with address/count bookkeeping and the one-deep in-flight tracker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         done      <= 1'b0;
`ifdef SRAM_STREAM_READER_LOOP_EN
         loop_q    <= 1'b0;
         base_addr <= '0;
         len_q     <= '0;
`endif
      end else begin
         done     <= 1'b0;
         inflight <= sram_ren;
         if (abort) begin
            state    <= S_IDLE;
            inflight <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (len == '0) begin
                        done <= 1'b1;
                     end else begin
                        state     <= S_RUN;
                        cur_addr  <= start_addr;
                        remaining <= len;
`ifdef SRAM_STREAM_READER_LOOP_EN
                        loop_q    <= loop;
                        base_addr <= start_addr;
                        len_q     <= len;
`endif
                     end
                  end
               end
               S_RUN: begin
                  if (sram_ren) begin
                     cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                     remaining <= remaining - (ADDR_WIDTH+1)'(1);
                     if (remaining == (ADDR_WIDTH+1)'(1)) begin
`ifdef SRAM_STREAM_READER_LOOP_EN
                        if (loop_q) begin
                           cur_addr  <= base_addr;
                           remaining <= len_q;
                        end else begin
                           state <= S_DRAIN;
                        end
`else
                        state <= S_DRAIN;
`endif
                     end
                  end
               end
               S_DRAIN: begin
                  if (pop && (occ == 2'd1) && !inflight) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - directed self-checking bench for sram_stream_reader with a behavioural sync SRAM
module tb_sram_stream_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [10:0] start_addr = '0;
   logic [11:0] len = '0;
   logic        abort = 1'b0;
   logic        busy, done, sram_ren, out_valid;
   logic [10:0] sram_addr;
   logic [31:0] sram_rdata = '0;
   logic [31:0] out_data;
   logic        out_ready = 1'b1;
`ifdef SRAM_STREAM_READER_LOOP_EN
   logic        loop_in = 1'b0;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   logic [31:0] mem [0:2047];

   always #5 clk = ~clk;

   sram_stream_reader #(.WIDTH(32), .ADDR_WIDTH(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
`ifdef SRAM_STREAM_READER_LOOP_EN
      .loop      (loop_in),
`endif
      .start_addr(start_addr),
      .len       (len),
      .abort     (abort),
      .busy      (busy),
      .done      (done),
      .sram_ren  (sram_ren),
      .sram_addr (sram_addr),
      .sram_rdata(sram_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = i;
   end

   always @(posedge clk) begin
      if (sram_ren) sram_rdata <= mem[sram_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // start is held for exactly one edge; returns at that edge + 1
   task automatic kick(input logic [10:0] a, input logic [11:0] l);
      step();
      start = 1'b1; start_addr = a; len = l;
      step();
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (sram_ren !== 1'b0) $display("FAIL reset_ren got %b want 0", sram_ren); else pass_cnt++;
      total_cnt++; if (sram_addr !== 11'h000) $display("FAIL reset_addr got %h want 000", sram_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
      step();
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_basic();
      logic        ev, edn, eb;
      logic [31:0] ed;
      out_ready = 1'b1;
      kick(11'h010, 12'd4);
      @(negedge clk);
      total_cnt++; if (sram_ren !== 1'b1 || sram_addr !== 11'h010)
         $display("FAIL basic_first_issue got ren=%b addr=%h want ren=1 addr=010", sram_ren, sram_addr); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_valid_e0 got %b want 0", out_valid); else pass_cnt++;
      for (int k = 1; k <= 7; k++) begin
         step();
         @(negedge clk);
         ev  = (k >= 2 && k <= 5);
         ed  = 32'h10 + 32'(k - 2);
         edn = (k == 6);
         eb  = (k <= 5);
         total_cnt++; if (out_valid !== ev) $display("FAIL basic_valid_c%0d got %b want %b", k, out_valid, ev); else pass_cnt++;
         if (ev) begin
            total_cnt++; if (out_data !== ed) $display("FAIL basic_data_c%0d got %h want %h", k, out_data, ed); else pass_cnt++;
         end
         total_cnt++; if (done !== edn) $display("FAIL basic_done_c%0d got %b want %b", k, done, edn); else pass_cnt++;
         total_cnt++; if (busy !== eb) $display("FAIL basic_busy_c%0d got %b want %b", k, busy, eb); else pass_cnt++;
      end
      idle(2);
   endtask

   task automatic test_wrap();
      logic [10:0] aq[$];
      logic [31:0] dq[$];
      logic [10:0] ea;
      int          dn = 0;
      out_ready = 1'b1;
      kick(11'h7FE, 12'd4);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sram_ren) aq.push_back(sram_addr);
         if (out_valid && out_ready) dq.push_back(out_data);
         if (done) dn++;
         step();
      end
      total_cnt++; if (aq.size() != 4) $display("FAIL wrap_ren_count got %0d want 4", aq.size()); else pass_cnt++;
      total_cnt++; if (dq.size() != 4) $display("FAIL wrap_word_count got %0d want 4", dq.size()); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         ea = 11'h7FE + 11'(i);
         total_cnt++; if (aq[i] !== ea) $display("FAIL wrap_addr%0d got %h want %h", i, aq[i], ea); else pass_cnt++;
         total_cnt++; if (dq[i] !== {21'b0, ea}) $display("FAIL wrap_data%0d got %h want %h", i, dq[i], {21'b0, ea}); else pass_cnt++;
      end
      total_cnt++; if (dn != 1) $display("FAIL wrap_done_count got %0d want 1", dn); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [31:0] dq[$];
      int          m_occ = 0;
      int          m_infl = 0;
      int          issue_viol = 0;
      int          valid_viol = 0;
      int          stall_viol = 0;
      logic        prev_v = 1'b0, prev_r = 1'b0, p;
      logic [31:0] prev_d = '0;
      logic        fin = 1'b0;
      out_ready = 1'b0;
      kick(11'h100, 12'd16);
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         p = out_valid && out_ready;
         if (sram_ren && (m_occ + m_infl - int'(p)) >= 2) issue_viol++;
         if (out_valid !== (m_occ != 0)) valid_viol++;
         if (prev_v && !prev_r && (out_valid !== 1'b1 || out_data !== prev_d)) stall_viol++;
         if (p) dq.push_back(out_data);
         if (done) fin = 1'b1;
         m_occ  = m_occ + m_infl - int'(p);
         m_infl = int'(sram_ren);
         prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
         step();
         out_ready = ($urandom_range(0, 99) < 30);
      end
      out_ready = 1'b1;
      total_cnt++; if (fin !== 1'b1) $display("FAIL bp_done_timeout got %b want 1", fin); else pass_cnt++;
      total_cnt++; if (dq.size() != 16) $display("FAIL bp_word_count got %0d want 16", dq.size()); else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         total_cnt++; if (dq[i] !== 32'h100 + 32'(i)) $display("FAIL bp_data%0d got %h want %h", i, dq[i], 32'h100 + 32'(i)); else pass_cnt++;
      end
      total_cnt++; if (issue_viol != 0) $display("FAIL bp_issue_rule got %0d violations want 0", issue_viol); else pass_cnt++;
      total_cnt++; if (valid_viol != 0) $display("FAIL bp_occupancy got %0d violations want 0", valid_viol); else pass_cnt++;
      total_cnt++; if (stall_viol != 0) $display("FAIL bp_stall_stable got %0d violations want 0", stall_viol); else pass_cnt++;
      idle(2);
   endtask

   task automatic test_len_zero();
      logic [31:0] dq[$];
      int          rens = 0;
      out_ready = 1'b1;
      kick(11'h020, 12'd0);
      @(negedge clk);
      total_cnt++; if (done !== 1'b1) $display("FAIL len0_done got %b want 1", done); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0 || sram_ren !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL len0_quiet got busy=%b ren=%b valid=%b want 0 0 0", busy, sram_ren, out_valid); else pass_cnt++;
      step();
      @(negedge clk);
      total_cnt++; if (done !== 1'b0) $display("FAIL len0_done_pulse got %b want 0", done); else pass_cnt++;
      // second start while busy must be ignored
      kick(11'h020, 12'd2);
      start = 1'b1; start_addr = 11'h040; len = 12'd5;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (sram_ren) rens++;
         if (out_valid && out_ready) dq.push_back(out_data);
         step();
         start = 1'b0;
      end
      total_cnt++; if (rens != 2) $display("FAIL busy_start_rens got %0d want 2", rens); else pass_cnt++;
      total_cnt++; if (dq.size() != 2) $display("FAIL busy_start_words got %0d want 2", dq.size()); else pass_cnt++;
      total_cnt++; if (dq[0] !== 32'h20 || dq[1] !== 32'h21)
         $display("FAIL busy_start_data got %h,%h want 20,21", dq[0], dq[1]); else pass_cnt++;
   endtask

   task automatic test_abort();
      logic [31:0] dq[$];
      int          bad = 0;
      int          dn = 0;
      // start and abort together while idle
      step();
      start = 1'b1; abort = 1'b1; start_addr = 11'h060; len = 12'd3;
      step();
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0 || sram_ren !== 1'b0)
         $display("FAIL abort_wins got busy=%b ren=%b want 0 0", busy, sram_ren); else pass_cnt++;
      // abort with one word buffered and one read in flight
      out_ready = 1'b0;
      kick(11'h030, 12'd8);
      step();
      step();
      abort = 1'b1;
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h30)
         $display("FAIL abort_pre_state got valid=%b data=%h want 1 30", out_valid, out_data); else pass_cnt++;
      step();
      abort = 1'b0;
      @(negedge clk);
      total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0 || sram_ren !== 1'b0)
         $display("FAIL abort_cleared got busy=%b valid=%b ren=%b want 0 0 0", busy, out_valid, sram_ren); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         if (done || out_valid || sram_ren) bad++;
      end
      total_cnt++; if (bad != 0) $display("FAIL abort_quiet got %0d active cycles want 0", bad); else pass_cnt++;
      out_ready = 1'b1;
      kick(11'h050, 12'd3);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (out_valid && out_ready) dq.push_back(out_data);
         if (done) dn++;
         step();
      end
      total_cnt++; if (dq.size() != 3) $display("FAIL abort_fresh_count got %0d want 3", dq.size()); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (dq[i] !== 32'h50 + 32'(i)) $display("FAIL abort_fresh_data%0d got %h want %h", i, dq[i], 32'h50 + 32'(i)); else pass_cnt++;
      end
      total_cnt++; if (dn != 1) $display("FAIL abort_fresh_done got %0d want 1", dn); else pass_cnt++;
   endtask

`ifdef SRAM_STREAM_READER_LOOP_EN
   task automatic test_loop();
      logic [31:0] ed;
      int          dn = 0;
      out_ready = 1'b1;
      loop_in = 1'b1;
      kick(11'h004, 12'd3);
      loop_in = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (done) dn++;
         if (k >= 2) begin
            ed = 32'h4 + 32'((k - 2) % 3);
            total_cnt++; if (out_valid !== 1'b1 || out_data !== ed)
               $display("FAIL loop_word_c%0d got valid=%b data=%h want 1 %h", k, out_valid, out_data, ed); else pass_cnt++;
         end
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clk);
      if (done) dn++;
      total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL loop_abort got busy=%b valid=%b want 0 0", busy, out_valid); else pass_cnt++;
      total_cnt++; if (dn != 0) $display("FAIL loop_no_done got %0d want 0", dn); else pass_cnt++;
      idle(2);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_abort();
`ifdef SRAM_STREAM_READER_LOOP_EN
      test_loop();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
